dmem_responder: RTL and testbench

- Responder (memory side) for the CPU's data-memory port: accepts DM_CS/DM_R/DM_W, DM_addr and DM_wdata, and returns DM_rdata in the same cycle.
- Contains a word-addressed RAM plus a small MMIO register window: free-running cycle counter, committed-write counter, sticky error status, scratch register.
- Sits beside the CPU in the top-level; the CPU's i_DM_rdata is driven from o_DM_rdata.

---
 rtl/dmem_if.sv | 28 ++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory bus between the CPU (master) and the memory-side responder.
// Read data returns combinationally in the same cycle as the request.
interface dmem_if;
    logic        i_DM_CS;
    logic        i_DM_R;
    logic        i_DM_W;
    logic [31:0] i_DM_addr;
    logic [31:0] i_DM_wdata;
    logic [31:0] o_DM_rdata;

    modport master (
        output i_DM_CS,
        output i_DM_R,
        output i_DM_W,
        output i_DM_addr,
        output i_DM_wdata,
        input  o_DM_rdata
    );

    modport slave (
        input  i_DM_CS,
        input  i_DM_R,
        input  i_DM_W,
        input  i_DM_addr,
        input  i_DM_wdata,
        output o_DM_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a 4-register MMIO window
// (cycle counter, write counter, sticky error status, scratch).
module dmem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h0000_FF00
) (
    input  logic        inclk,
    input  logic        rst,
    dmem_if.slave       dm,
    output logic        o_err,
    output logic [31:0] o_err_addr,
    input  logic [31:0] test_dm_addr,
    output logic [31:0] test_dm_data
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [31:0] MMIO_LAST = MMIO_BASE + 32'd15;
    localparam logic [31:0] A_CYCLE   = MMIO_BASE;
    localparam logic [31:0] A_WCOUNT  = MMIO_BASE + 32'd4;
    localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'd8;
    localparam logic [31:0] A_SCRATCH = MMIO_BASE + 32'd12;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_cycle;
    logic [31:0] r_wcount;
    logic [2:0]  r_status;
    logic [31:0] r_scratch;
    logic [31:0] r_err_addr;

    logic          w_mis;
    logic          w_ram_hit;
    logic          w_mmio_hit;
    logic          w_unm;
    logic          w_rd;
    logic          w_wr;
    logic          w_err;
    logic          w_clr;
    logic          w_sel_cyc;
    logic          w_sel_wcnt;
    logic          w_sel_stat;
    logic          w_sel_scr;
    logic [AW-1:0] w_widx;
    logic [AW-1:0] w_tidx;
    logic          w_tin;
    logic [31:0]   w_rdata;

    // Address decode; RAM takes priority should the windows ever overlap.
    always_comb begin
        w_mis      = (dm.i_DM_addr[1:0] != 2'b00);
        w_ram_hit  = !w_mis && (dm.i_DM_addr < RAM_BYTES);
        w_mmio_hit = !w_mis && !w_ram_hit
                   && (dm.i_DM_addr >= MMIO_BASE)
                   && (dm.i_DM_addr <= MMIO_LAST);
        w_unm      = !w_mis && !w_ram_hit && !w_mmio_hit;
        w_sel_cyc  = w_mmio_hit && (dm.i_DM_addr == A_CYCLE);
        w_sel_wcnt = w_mmio_hit && (dm.i_DM_addr == A_WCOUNT);
        w_sel_stat = w_mmio_hit && (dm.i_DM_addr == A_STATUS);
        w_sel_scr  = w_mmio_hit && (dm.i_DM_addr == A_SCRATCH);
        w_widx     = dm.i_DM_addr[AW+1:2];
    end

    always_comb begin
        w_rd  = dm.i_DM_CS && dm.i_DM_R;
        w_wr  = dm.i_DM_CS && dm.i_DM_W;
        w_err = (w_rd || w_wr) && (w_mis || w_unm);
        w_clr = w_wr && w_sel_stat && dm.i_DM_wdata[0];
    end

    always_comb begin
        w_rdata = 32'h0;
        if (w_rd) begin
            unique case (1'b1)
                w_ram_hit:  w_rdata = r_mem[w_widx];
                w_sel_cyc:  w_rdata = r_cycle;
                w_sel_wcnt: w_rdata = r_wcount;
                w_sel_stat: w_rdata = {29'h0, r_status};
                w_sel_scr:  w_rdata = r_scratch;
                default:    w_rdata = 32'h0;
            endcase
        end
    end

    assign dm.o_DM_rdata = w_rdata;
    assign o_err         = r_status[0];
    assign o_err_addr    = r_err_addr;

    always_comb begin
        w_tidx       = test_dm_addr[AW-1:0];
        w_tin        = (test_dm_addr < 32'(DEPTH));
        test_dm_data = w_tin ? r_mem[w_tidx] : 32'h0;
    end

    always_ff @(posedge inclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_wr && w_ram_hit) begin
            r_mem[w_widx] <= dm.i_DM_wdata;
        end
    end

    always_ff @(posedge inclk) begin
        if (rst) begin
            r_cycle   <= 32'h0;
            r_wcount  <= 32'h0;
            r_scratch <= 32'h0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr && w_ram_hit && (r_wcount != 32'hFFFF_FFFF)) begin
                r_wcount <= r_wcount + 32'd1;
            end
            if (w_wr && w_sel_scr) begin
                r_scratch <= dm.i_DM_wdata;
            end
        end
    end

    // A new error beats a same-cycle clear and re-arms address capture.
    always_ff @(posedge inclk) begin
        if (rst) begin
            r_status   <= 3'b000;
            r_err_addr <= 32'h0;
        end else if (w_err) begin
            r_status <= (w_clr ? 3'b000 : r_status)
                      | {w_unm, w_mis, 1'b1};
            if (w_clr || !r_status[0]) begin
                r_err_addr <= dm.i_DM_addr;
            end
        end else if (w_clr) begin
            r_status   <= 3'b000;
            r_err_addr <= 32'h0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed plan checks plus randomized traffic
// compared every cycle against a behavioural memory/MMIO model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_FF00;

    logic        clk;
    logic        rst;
    logic        o_err;
    logic [31:0] o_err_addr;
    logic [31:0] test_dm_addr;
    logic [31:0] test_dm_data;

    dmem_if dm ();

    dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
        .inclk        (clk),
        .rst          (rst),
        .dm           (dm),
        .o_err        (o_err),
        .o_err_addr   (o_err_addr),
        .test_dm_addr (test_dm_addr),
        .test_dm_data (test_dm_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_cycle;
    logic [31:0] m_wcount;
    logic [2:0]  m_status;
    logic [31:0] m_scratch;
    logic [31:0] m_eaddr;

    logic [31:0] last_rd;
    logic [31:0] last_td;
    logic        last_err;
    logic [31:0] last_eaddr;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input bit cs, input bit r,
                                               input logic [31:0] a);
        if (!(cs && r) || a[1:0] != 2'b00) return 32'h0;
        if (a < DEPTH * 4) return m_mem[a >> 2];
        if (a == BASE) return m_cycle;
        if (a == BASE + 4) return m_wcount;
        if (a == BASE + 8) return {29'h0, m_status};
        if (a == BASE + 12) return m_scratch;
        return 32'h0;
    endfunction

    task automatic model_update(input bit rs, input bit cs, input bit r,
                                input bit w, input logic [31:0] a,
                                input logic [31:0] wd);
        bit mis, ram, mm, unm, first;
        if (rs) begin
            foreach (m_mem[i]) m_mem[i] = 32'h0;
            m_cycle = 0; m_wcount = 0; m_status = 0;
            m_scratch = 0; m_eaddr = 0;
            return;
        end
        m_cycle = m_cycle + 1;
        mis = (a[1:0] != 2'b00);
        ram = !mis && (a < DEPTH * 4);
        mm  = !mis && !ram && (a >= BASE) && (a <= BASE + 15);
        unm = !mis && !ram && !mm;
        first = !m_status[0];
        if (cs && w && a == BASE + 8 && wd[0]) begin
            m_status = 0; m_eaddr = 0; first = 1;
        end
        if (cs && (r || w) && (mis || unm)) begin
            m_status = m_status | {unm, mis, 1'b1};
            if (first) m_eaddr = a;
        end else if (cs && w) begin
            if (ram) begin
                m_mem[a >> 2] = wd;
                if (m_wcount != 32'hFFFF_FFFF) m_wcount = m_wcount + 1;
            end else if (a == BASE + 12) begin
                m_scratch = wd;
            end
        end
    endtask

    task automatic step(input bit rs, input bit cs, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ta);
        logic [31:0] exp_td;
        @(negedge clk);
        rst = rs;
        dm.i_DM_CS = cs; dm.i_DM_R = r; dm.i_DM_W = w;
        dm.i_DM_addr = a; dm.i_DM_wdata = wd;
        test_dm_addr = ta;
        #1;
        exp_td = (ta < DEPTH) ? m_mem[ta[9:0]] : 32'h0;
        last_rd = dm.o_DM_rdata; last_td = test_dm_data;
        last_err = o_err; last_eaddr = o_err_addr;
        chk("rdata", dm.o_DM_rdata, model_read(cs, r, a));
        chk("err", {31'h0, o_err}, {31'h0, m_status[0]});
        chk("err_addr", o_err_addr, m_eaddr);
        chk("test_data", test_dm_data, exp_td);
        @(posedge clk);
        model_update(rs, cs, r, w, a, wd);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ta);
        step(0, 1, 1, 0, a, 32'h0, ta);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        step(0, 1, 0, 1, a, wd, 32'h0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2: return 32'($urandom_range(0, 31)) << 2;
            3:       return 32'($urandom_range(0, DEPTH - 1)) << 2;
            4:       return (DEPTH * 4) - 32'($urandom_range(0, 1)) * 4;
            5, 6:    return BASE + (32'($urandom_range(0, 3)) << 2);
            7:       return {$urandom_range(0, 1023), 2'b00}
                            | 32'($urandom_range(1, 3));
            8:       return 32'h0001_0000 + (32'($urandom_range(0, 255)) << 2);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; test_dm_addr = 0;
        dm.i_DM_CS = 0; dm.i_DM_R = 0; dm.i_DM_W = 0;
        dm.i_DM_addr = 0; dm.i_DM_wdata = 0;
        @(posedge clk);
        model_update(1, 0, 0, 0, 32'h0, 32'h0);

        // reset state
        rd(BASE + 8, 32'h0);
        chk("rst_status", last_rd, 32'h0);
        chk("rst_err", {31'h0, last_err}, 32'h0);
        chk("rst_eaddr", last_eaddr, 32'h0);

        wr(32'h10, 32'hCAFE_F00D);
        rd(32'h10, 32'd4);
        chk("rd_0x10", last_rd, 32'hCAFE_F00D);
        chk("tdm_idx4", last_td, 32'hCAFE_F00D);
        rd(BASE + 4, 32'h0);
        chk("wcount1", last_rd, 32'h1);

        // read-before-write
        wr(32'h20, 32'hAAAA_5555);
        step(0, 1, 1, 1, 32'h20, 32'h1234_5678, 32'h0);
        chk("rbw_old", last_rd, 32'hAAAA_5555);
        rd(32'h20, 32'h0);
        chk("rbw_new", last_rd, 32'h1234_5678);

        // misaligned then unmapped error
        wr(32'h13, 32'h5A5A_5A5A);
        rd(32'h10, 32'd4);
        chk("mis_noeffect", last_rd, 32'hCAFE_F00D);
        chk("mis_err", {31'h0, last_err}, 32'h1);
        chk("mis_eaddr", last_eaddr, 32'h13);
        rd(BASE + 8, 32'h0);
        chk("status3", last_rd, 32'h3);
        rd(32'h0001_0000, 32'h0);
        chk("unm_rdata", last_rd, 32'h0);
        rd(BASE + 8, 32'h0);
        chk("status7", last_rd, 32'h7);
        chk("first_wins", last_eaddr, 32'h13);

        // clear, then back-to-back clear and new error
        wr(BASE + 8, 32'h1);
        rd(BASE + 8, 32'h0);
        chk("clr_status", last_rd, 32'h0);
        chk("clr_err", {31'h0, last_err}, 32'h0);
        wr(32'h0002_0000, 32'h0);
        wr(BASE + 8, 32'h1);
        rd(32'h22, 32'h0);
        rd(BASE + 8, 32'h0);
        chk("reerr_status", last_rd, 32'h3);
        chk("reerr_eaddr", last_eaddr, 32'h22);

        // cycle counter after idle, reset with pending write
        step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 100; i++) idle();
        rd(BASE, 32'h0);
        chk("cycle100", last_rd, 32'd100);
        wr(32'h0, 32'h0000_0055);
        step(1, 1, 0, 1, 32'h0, 32'hDEAD_BEEF, 32'h0);
        rd(BASE, 32'h0);
        chk("cycle_rst", last_rd, 32'h0);
        chk("ram0_rst", last_td, 32'h0);

        // scratch and read-only cycle writes
        wr(BASE + 12, 32'hFFFF_FFFF);
        wr(BASE, 32'h0000_1234);
        rd(BASE + 12, 32'h0);
        chk("scratch", last_rd, 32'hFFFF_FFFF);
        rd(BASE, 32'h0);
        chk("cycle_ro", last_rd, 32'd4);
        chk("scr_noerr", {31'h0, last_err}, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ta;
            ta = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31))
                                            : 32'($urandom_range(0, 1100));
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rand_addr(), $urandom, ta);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
